// File: rtl/uart_cmd_pkg.sv
// Shared constants, FSM encoding and checksum helper for the UART command sequencer.
package uart_cmd_pkg;

  typedef logic [2:0] state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CMD   = 3'd1;
  localparam state_t ST_ADDR  = 3'd2;
  localparam state_t ST_LEN   = 3'd3;
  localparam state_t ST_DATA  = 3'd4;
  localparam state_t ST_CHK   = 3'd5;
  localparam state_t ST_WRITE = 3'd6;
  localparam state_t ST_RESP  = 3'd7;

  function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // States in which a frame is open and the inter-byte timer runs.
  function automatic logic in_frame(input state_t st);
    return (st >= ST_CMD) && (st <= ST_CHK);
  endfunction

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// Byte-stream, register-write and transmitter handshake bundle of the command sequencer.
interface uart_cmd_sequencer_if #(parameter int ADDR_W = 8);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;

  modport master (
    input  rx_data, rx_valid, tx_busy,
    output wr_en, wr_addr, wr_data, tx_data, tx_start
  );

  modport slave (
    output rx_data, rx_valid, tx_busy,
    input  wr_en, wr_addr, wr_data, tx_data, tx_start
  );
endinterface

// File: rtl/cmd_payload_buf.sv
// Payload byte store: one write port fed from the DATA phase, one combinational read port for the burst.
module cmd_payload_buf #(
  parameter int MAX_LEN = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem_r [MAX_LEN];

  // Capture payload bytes; contents are only read after being written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Frame parser behind the UART receiver: verifies write frames, bursts the payload into the
// register bank and answers each frame with ACK/NAK through the transmitter handshake.
module uart_cmd_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_cmd_sequencer_if.master  bus,
  output logic                  busy,
  output logic                  err_timeout,
  output logic                  rx_overrun
);
  import uart_cmd_pkg::*;

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t            state_r, state_n_s;
  logic [ADDR_W-1:0] base_r, wr_addr_r;
  logic [LEN_W-1:0]  len_r, idx_r, bidx_r;
  logic [7:0]        csum_r, wr_data_r, tx_data_r, rd_data_s;
  logic [TMO_W-1:0]  tmo_r;
  logic              nak_r, wr_en_r, tx_start_r, busy_r, err_timeout_r, rx_overrun_r;
  logic              frame_s, timeout_s, len_ok_s, chk_ok_s, data_last_s, burst_done_s, buf_we_s;

  assign frame_s      = in_frame(state_r);
  // An arriving byte beats the terminal count.
  assign timeout_s    = frame_s && !bus.rx_valid && (tmo_r == TMO_LAST);
  assign len_ok_s     = (bus.rx_data != 8'd0) && (bus.rx_data <= 8'(MAX_LEN));
  assign chk_ok_s     = (bus.rx_data == csum_r);
  assign data_last_s  = ((idx_r + LEN_W'(1)) == len_r);
  assign burst_done_s = (bidx_r == len_r);
  assign buf_we_s     = (state_r == ST_DATA) && bus.rx_valid;

  cmd_payload_buf #(
    .MAX_LEN (MAX_LEN),
    .IDX_W   (IDX_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we_s),
    .waddr (idx_r[IDX_W-1:0]),
    .wdata (bus.rx_data),
    .raddr (bidx_r[IDX_W-1:0]),
    .rdata (rd_data_s)
  );

  // Next-state decode; every frame state advances only on an accepted byte.
  always_comb begin
    state_n_s = state_r;
    if (timeout_s) begin
      state_n_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) state_n_s = ST_CMD;
                  else state_n_s = ST_IDLE;
        ST_CMD:   if (bus.rx_valid) state_n_s = (bus.rx_data == CMD_WRITE) ? ST_ADDR : ST_RESP;
                  else state_n_s = ST_CMD;
        ST_ADDR:  if (bus.rx_valid) state_n_s = ST_LEN;
                  else state_n_s = ST_ADDR;
        ST_LEN:   if (bus.rx_valid) state_n_s = len_ok_s ? ST_DATA : ST_RESP;
                  else state_n_s = ST_LEN;
        ST_DATA:  if (bus.rx_valid) state_n_s = data_last_s ? ST_CHK : ST_DATA;
                  else state_n_s = ST_DATA;
        ST_CHK:   if (bus.rx_valid) state_n_s = chk_ok_s ? ST_WRITE : ST_RESP;
                  else state_n_s = ST_CHK;
        ST_WRITE: if (burst_done_s) state_n_s = ST_RESP;
                  else state_n_s = ST_WRITE;
        ST_RESP:  if (!bus.tx_busy) state_n_s = ST_IDLE;
                  else state_n_s = ST_RESP;
        default:  state_n_s = ST_IDLE;
      endcase
    end
  end

  // Datapath and registered outputs; the first beat launches with the accepted CHK byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      base_r        <= {ADDR_W{1'b0}};
      len_r         <= {LEN_W{1'b0}};
      idx_r         <= {LEN_W{1'b0}};
      bidx_r        <= {LEN_W{1'b0}};
      csum_r        <= 8'h00;
      tmo_r         <= {TMO_W{1'b0}};
      nak_r         <= 1'b0;
      wr_en_r       <= 1'b0;
      wr_addr_r     <= {ADDR_W{1'b0}};
      wr_data_r     <= 8'h00;
      tx_data_r     <= 8'h00;
      tx_start_r    <= 1'b0;
      busy_r        <= 1'b0;
      err_timeout_r <= 1'b0;
      rx_overrun_r  <= 1'b0;
    end else begin
      state_r       <= state_n_s;
      busy_r        <= (state_n_s != ST_IDLE);
      wr_en_r       <= 1'b0;
      tx_start_r    <= 1'b0;
      err_timeout_r <= timeout_s;
      rx_overrun_r  <= bus.rx_valid && ((state_r == ST_WRITE) || (state_r == ST_RESP));
      if (frame_s && !bus.rx_valid && !timeout_s) tmo_r <= tmo_r + TMO_W'(1);
      else tmo_r <= {TMO_W{1'b0}};

      case (state_r)
        ST_IDLE: if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
          csum_r <= 8'h00;
          idx_r  <= {LEN_W{1'b0}};
          bidx_r <= {LEN_W{1'b0}};
        end
        ST_CMD: if (bus.rx_valid) begin
          csum_r <= chk_next(csum_r, bus.rx_data);
          nak_r  <= (bus.rx_data != CMD_WRITE);
        end
        ST_ADDR: if (bus.rx_valid) begin
          csum_r <= chk_next(csum_r, bus.rx_data);
          base_r <= ADDR_W'(bus.rx_data);
        end
        ST_LEN: if (bus.rx_valid) begin
          csum_r <= chk_next(csum_r, bus.rx_data);
          len_r  <= LEN_W'(bus.rx_data);
          idx_r  <= {LEN_W{1'b0}};
          nak_r  <= !len_ok_s;
        end
        ST_DATA: if (bus.rx_valid) begin
          csum_r <= chk_next(csum_r, bus.rx_data);
          idx_r  <= idx_r + LEN_W'(1);
        end
        ST_CHK: if (bus.rx_valid) begin
          nak_r <= !chk_ok_s;
          if (chk_ok_s) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= base_r;
            wr_data_r <= rd_data_s;
            bidx_r    <= LEN_W'(1);
          end
        end
        ST_WRITE: if (!burst_done_s) begin
          wr_en_r   <= 1'b1;
          wr_addr_r <= base_r + ADDR_W'(bidx_r);
          wr_data_r <= rd_data_s;
          bidx_r    <= bidx_r + LEN_W'(1);
        end
        ST_RESP: if (!bus.tx_busy) begin
          tx_start_r <= 1'b1;
          tx_data_r  <= nak_r ? RSP_NAK : RSP_ACK;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.wr_en    = wr_en_r;
  assign bus.wr_addr  = wr_addr_r;
  assign bus.wr_data  = wr_data_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.tx_start = tx_start_r;
  assign busy         = busy_r;
  assign err_timeout  = err_timeout_r;
  assign rx_overrun   = rx_overrun_r;

endmodule
